// File: rtl/io_bus_pkg.sv
// Shared I/O bus definitions: strobe encodings, status bit layout and defaults.
package io_bus_pkg;

  localparam logic IO_DIR_IN   = 1'b0;
  localparam logic IO_DIR_OUT  = 1'b1;
  localparam logic IO_CYC_DATA = 1'b0;
  localparam logic IO_CYC_ADDR = 1'b1;

  localparam int ST_RX_NOT_FULL  = 0;
  localparam int ST_TX_NOT_EMPTY = 1;
  localparam int ST_UNDERRUN     = 2;
  localparam int ST_OVERRUN      = 3;

  localparam logic [7:0] DEV_ADDR_DEFAULT   = 8'h0F;
  localparam int         FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IO_OP_OUT_ADDR = 2'd0,
    IO_OP_OUT_DATA = 2'd1,
    IO_OP_IN_ADDR  = 2'd2,
    IO_OP_IN_DATA  = 2'd3
  } io_op_e;

  // Classify the current bus cycle from the direction and data/address strobes.
  function automatic io_op_e decode_op(input logic dir, input logic cyc);
    io_op_e op;
    case ({dir, cyc})
      {IO_DIR_OUT, IO_CYC_ADDR}: op = IO_OP_OUT_ADDR;
      {IO_DIR_OUT, IO_CYC_DATA}: op = IO_OP_OUT_DATA;
      {IO_DIR_IN,  IO_CYC_ADDR}: op = IO_OP_IN_ADDR;
      {IO_DIR_IN,  IO_CYC_DATA}: op = IO_OP_IN_DATA;
      default:                   op = IO_OP_IN_DATA;
    endcase
    return op;
  endfunction

  // Assemble the status byte returned on an IN Addr cycle.
  function automatic logic [7:0] pack_status(input logic overrun, input logic underrun,
                                             input logic tx_not_empty, input logic rx_not_full);
    logic [7:0] st;
    st                  = 8'h00;
    st[ST_OVERRUN]      = overrun;
    st[ST_UNDERRUN]     = underrun;
    st[ST_TX_NOT_EMPTY] = tx_not_empty;
    st[ST_RX_NOT_FULL]  = rx_not_full;
    return st;
  endfunction

endpackage

// File: rtl/io_port_responder_sync_fifo.sv
// Small synchronous FIFO. Push into a full FIFO and pop from an empty FIFO are
// ignored, so callers may present requests without pre-qualifying them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) wr_ptr_d = wr_ptr_q + AW'(1'b1);
    else           wr_ptr_d = wr_ptr_q;
    if (pop_ok_s)  rd_ptr_d = rd_ptr_q + AW'(1'b1);
    else           rd_ptr_d = rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1'b1);
      2'b01:   count_d = count_q - (AW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_port_responder.sv
// Device-side responder for the CPU I/O bus: address select, CPU->device and
// device->CPU byte FIFOs, and a status byte with sticky overrun/underrun flags.
module io_port_responder
  import io_bus_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         DEPTH    = FIFO_DEPTH_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       io_clk_s,
  input  logic       io_clk_e,
  input  logic       io_input_or_output,
  input  logic       io_data_or_address,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_out_en,
  output logic [7:0] dev_rx_data,
  output logic       dev_rx_valid,
  input  logic       dev_rx_ready,
  input  logic [7:0] dev_tx_data,
  input  logic       dev_tx_valid,
  output logic       dev_tx_ready,
  output logic       selected
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic          s_q, e_q;
  logic          selected_q, selected_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          s_rise_s, e_fall_s;
  io_op_e        op_s;
  logic          rx_push_s, tx_pop_s;
  logic          overrun_set_s, underrun_set_s, flag_clr_s;
  logic          rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic [CW-1:0] rx_count_s, tx_count_s;
  logic [7:0]    tx_head_s, status_s, bus_out_s;

  assign s_rise_s = io_clk_s & ~s_q;
  assign e_fall_s = ~io_clk_e & e_q;
  assign op_s     = decode_op(io_input_or_output, io_data_or_address);
  assign status_s = pack_status(overrun_q, underrun_q,
                                (tx_count_s != '0), (rx_count_s != CNT_FULL));

  // Drive enable is combinational so the bus is owned for the whole clk_e window.
  assign bus_out_en   = io_clk_e & selected_q & (io_input_or_output == IO_DIR_IN);
  assign bus_out      = bus_out_s;
  assign selected     = selected_q;
  assign dev_rx_valid = ~rx_empty_s;
  assign dev_tx_ready = ~tx_full_s;

  // Strobe history; loading it during reset suppresses events from strobes held across release.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s_q <= io_clk_s;
      e_q <= io_clk_e;
    end else begin
      s_q <= io_clk_s;
      e_q <= io_clk_e;
    end
  end

  // Decode bus events into FIFO requests, selection update, flag updates and bus data.
  always_comb begin
    selected_d     = selected_q;
    rx_push_s      = 1'b0;
    tx_pop_s       = 1'b0;
    overrun_set_s  = 1'b0;
    underrun_set_s = 1'b0;
    flag_clr_s     = 1'b0;
    bus_out_s      = 8'h00;
    case (op_s)
      IO_OP_OUT_ADDR: begin
        if (s_rise_s) selected_d = (bus_in == DEV_ADDR);
        else          selected_d = selected_q;
      end
      IO_OP_OUT_DATA: begin
        if (s_rise_s && selected_q) begin
          if (rx_full_s) overrun_set_s = 1'b1;
          else           rx_push_s     = 1'b1;
        end else begin
          rx_push_s = 1'b0;
        end
      end
      IO_OP_IN_DATA: begin
        if (bus_out_en && !tx_empty_s) bus_out_s = tx_head_s;
        else                           bus_out_s = 8'h00;
        if (e_fall_s && selected_q) begin
          if (tx_empty_s) underrun_set_s = 1'b1;
          else            tx_pop_s       = 1'b1;
        end else begin
          tx_pop_s = 1'b0;
        end
      end
      IO_OP_IN_ADDR: begin
        if (bus_out_en) bus_out_s = status_s;
        else            bus_out_s = 8'h00;
        if (e_fall_s && selected_q) flag_clr_s = 1'b1;
        else                        flag_clr_s = 1'b0;
      end
      default: begin
        bus_out_s = 8'h00;
      end
    endcase
    // A flag set in the same cycle as a status read-clear survives.
    overrun_d  = (overrun_q  & ~flag_clr_s) | overrun_set_s;
    underrun_d = (underrun_q & ~flag_clr_s) | underrun_set_s;
  end

  // Selection and sticky error flag registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      selected_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      selected_q <= selected_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (sys_clk),
    .reset     (reset),
    .push      (rx_push_s),
    .push_data (bus_in),
    .pop       (dev_rx_ready),
    .pop_data  (dev_rx_data),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .count     (rx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (sys_clk),
    .reset     (reset),
    .push      (dev_tx_valid),
    .push_data (dev_tx_data),
    .pop       (tx_pop_s),
    .pop_data  (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .count     (tx_count_s)
  );

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: directed CPU/device traffic with
// expected bus reads and device-side bytes queued, checked by a monitor.
module tb_io_port_responder;
  import io_bus_pkg::*;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       io_clk_s, io_clk_e, io_input_or_output, io_data_or_address;
  logic [7:0] bus_in, bus_out, dev_rx_data, dev_tx_data;
  logic       bus_out_en, dev_rx_valid, dev_rx_ready, dev_tx_valid, dev_tx_ready, selected;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] bus_q[$];
  logic [7:0] rx_q[$];
  logic prev_en = 1'b0, prev_s = 1'b0, prev_e = 1'b0;

  io_port_responder dut (
    .sys_clk(sys_clk), .reset(reset),
    .io_clk_s(io_clk_s), .io_clk_e(io_clk_e),
    .io_input_or_output(io_input_or_output), .io_data_or_address(io_data_or_address),
    .bus_in(bus_in), .bus_out(bus_out), .bus_out_en(bus_out_en),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
    .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready),
    .selected(selected)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: compare bus reads and device-side consumption against the queues.
  always @(negedge sys_clk) begin
    logic [7:0] exp;
    if (!reset) begin
      if (bus_out_en && !prev_en) begin
        if (bus_q.size() == 0) check("bus_read_unexpected", bus_out, 8'hxx);
        else begin
          exp = bus_q.pop_front();
          check("bus_read", bus_out, exp);
        end
      end
      if (!bus_out_en) check("bus_idle_zero", bus_out, 8'h00);
      if (dev_rx_valid && dev_rx_ready) begin
        if (rx_q.size() == 0) check("rx_pop_unexpected", dev_rx_data, 8'hxx);
        else begin
          exp = rx_q.pop_front();
          check("rx_pop", dev_rx_data, exp);
        end
      end
      if (io_clk_s && !prev_s && io_clk_e && !prev_e) check("strobes_rise_together", 8'h01, 8'h00);
    end
    prev_en = bus_out_en;
    prev_s  = io_clk_s;
    prev_e  = io_clk_e;
  end

  task automatic cpu_out(input logic cyc, input logic [7:0] val);
    @(posedge sys_clk); #1;
    io_input_or_output = IO_DIR_OUT; io_data_or_address = cyc; bus_in = val; io_clk_s = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 io_clk_s = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic cpu_in(input logic cyc, input logic [7:0] exp);
    bus_q.push_back(exp);
    @(posedge sys_clk); #1;
    io_input_or_output = IO_DIR_IN; io_data_or_address = cyc; io_clk_e = 1'b1;
    @(negedge sys_clk);
    check("in_en_high", {7'd0, bus_out_en}, 8'h01);
    repeat (3) @(posedge sys_clk);
    #1 io_clk_e = 1'b0;
    @(negedge sys_clk);
    check("in_en_low", {7'd0, bus_out_en}, 8'h00);
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic dev_push(input logic [7:0] d);
    @(posedge sys_clk); #1;
    dev_tx_valid = 1'b1; dev_tx_data = d;
    @(posedge sys_clk); #1;
    dev_tx_valid = 1'b0;
  endtask

  task automatic drain_rx();
    int i;
    @(posedge sys_clk); #1 dev_rx_ready = 1'b1;
    i = 0;
    @(negedge sys_clk);
    while (dev_rx_valid && i < 20) begin
      @(negedge sys_clk);
      i++;
    end
    check("rx_drained_valid", {7'd0, dev_rx_valid}, 8'h00);
    @(posedge sys_clk); #1 dev_rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_clk_s = 1'b0; io_clk_e = 1'b0; io_input_or_output = 1'b0;
    io_data_or_address = 1'b0; bus_in = 8'h00; dev_rx_ready = 1'b0;
    dev_tx_valid = 1'b0; dev_tx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    @(negedge sys_clk);
    check("rst_selected", {7'd0, selected}, 8'h00);
    check("rst_rx_valid", {7'd0, dev_rx_valid}, 8'h00);
    check("rst_tx_ready", {7'd0, dev_tx_ready}, 8'h01);
    check("rst_bus_en", {7'd0, bus_out_en}, 8'h00);

    // Address select with one-cycle visibility.
    @(posedge sys_clk); #1;
    io_input_or_output = IO_DIR_OUT; io_data_or_address = IO_CYC_ADDR; bus_in = 8'h0F; io_clk_s = 1'b1;
    @(negedge sys_clk);
    check("sel_not_yet", {7'd0, selected}, 8'h00);
    @(negedge sys_clk);
    check("sel_next_cycle", {7'd0, selected}, 8'h01);
    @(posedge sys_clk); #1 io_clk_s = 1'b0;
    repeat (2) @(posedge sys_clk);
    cpu_out(IO_CYC_ADDR, 8'h10);
    @(negedge sys_clk) check("desel_other_addr", {7'd0, selected}, 8'h00);
    cpu_out(IO_CYC_DATA, 8'hAA);
    @(negedge sys_clk) check("desel_data_ignored", {7'd0, dev_rx_valid}, 8'h00);

    // OUT Data: one entry per long pulse.
    cpu_out(IO_CYC_ADDR, 8'h0F);
    cpu_out(IO_CYC_DATA, 8'h11);
    @(negedge sys_clk) check("rx_head_first", dev_rx_data, 8'h11);
    cpu_out(IO_CYC_DATA, 8'h22);
    @(negedge sys_clk) check("rx_head_kept", dev_rx_data, 8'h11);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    drain_rx();

    // Overrun: fifth byte dropped, status read then cleared.
    cpu_out(IO_CYC_DATA, 8'h01);
    cpu_out(IO_CYC_DATA, 8'h02);
    cpu_out(IO_CYC_DATA, 8'h03);
    cpu_out(IO_CYC_DATA, 8'h04);
    cpu_out(IO_CYC_DATA, 8'h05);
    cpu_in(IO_CYC_ADDR, 8'h08);
    cpu_in(IO_CYC_ADDR, 8'h00);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03); rx_q.push_back(8'h04);
    drain_rx();

    // IN Data: two bytes, then an empty read raising underrun.
    dev_push(8'h5A);
    dev_push(8'hC3);
    cpu_in(IO_CYC_DATA, 8'h5A);
    cpu_in(IO_CYC_DATA, 8'hC3);
    cpu_in(IO_CYC_DATA, 8'h00);
    cpu_in(IO_CYC_ADDR, 8'h05);

    // Full tx FIFO: push refused in the pop cycle, accepted the next.
    dev_push(8'h10); dev_push(8'h20); dev_push(8'h30); dev_push(8'h40);
    @(negedge sys_clk) check("tx_full_ready", {7'd0, dev_tx_ready}, 8'h00);
    bus_q.push_back(8'h10);
    @(posedge sys_clk); #1;
    io_input_or_output = IO_DIR_IN; io_data_or_address = IO_CYC_DATA; io_clk_e = 1'b1;
    dev_tx_valid = 1'b1; dev_tx_data = 8'h50;
    repeat (3) @(posedge sys_clk);
    #1 io_clk_e = 1'b0;
    @(negedge sys_clk) check("tx_ready_pop_cycle", {7'd0, dev_tx_ready}, 8'h00);
    @(posedge sys_clk); #1;
    @(negedge sys_clk) check("tx_ready_after_pop", {7'd0, dev_tx_ready}, 8'h01);
    @(posedge sys_clk); #1 dev_tx_valid = 1'b0;
    @(negedge sys_clk) check("tx_ready_refilled", {7'd0, dev_tx_ready}, 8'h00);
    cpu_in(IO_CYC_DATA, 8'h20);
    cpu_in(IO_CYC_DATA, 8'h30);
    cpu_in(IO_CYC_DATA, 8'h40);
    cpu_in(IO_CYC_DATA, 8'h50);
    cpu_in(IO_CYC_ADDR, 8'h01);

    // Reset in the middle of an IN Data window with both FIFOs holding data.
    cpu_out(IO_CYC_DATA, 8'hA1);
    cpu_out(IO_CYC_DATA, 8'hA2);
    dev_push(8'hB1);
    dev_push(8'hB2);
    bus_q.push_back(8'hB1);
    @(posedge sys_clk); #1;
    io_input_or_output = IO_DIR_IN; io_data_or_address = IO_CYC_DATA; io_clk_e = 1'b1;
    @(posedge sys_clk); #1 reset = 1'b1;
    @(posedge sys_clk); #1 reset = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_bus_en", {7'd0, bus_out_en}, 8'h00);
    check("mid_rst_selected", {7'd0, selected}, 8'h00);
    check("mid_rst_rx_valid", {7'd0, dev_rx_valid}, 8'h00);
    check("mid_rst_tx_ready", {7'd0, dev_tx_ready}, 8'h01);
    repeat (2) @(posedge sys_clk);
    #1 io_clk_e = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) check("post_rst_selected", {7'd0, selected}, 8'h00);
    cpu_out(IO_CYC_ADDR, 8'h0F);
    cpu_in(IO_CYC_ADDR, 8'h01);

    repeat (3) @(posedge sys_clk);
    check("bus_q_drained", 8'(bus_q.size()), 8'h00);
    check("rx_q_drained", 8'(rx_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Device-side responder for the processor's I/O bus. It decodes the control section's IO_clk_s, IO_clk_e, IO_input_or_output and IO_data_or_address strobes.
- It latches device selection on OUT Addr, accepts bytes on OUT Data, and returns bytes on IN Data. IN Addr returns a status byte.
- Two small FIFOs decouple CPU-timed transfers from a valid/ready peripheral interface such as a keyboard or display.

Parameters:
- DEV_ADDR, 8'h0F: I/O address this device answers to.
- DEPTH, 4: entries per FIFO. Must be a power of 2 and at least 2.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- io_clk_s  in  1  I/O set strobe from control section, level, sys_clk domain.
- io_clk_e  in  1  I/O enable strobe, level, sys_clk domain.
- io_input_or_output  in  1  1 = OUT (CPU to device), 0 = IN.
- io_data_or_address  in  1  1 = address cycle, 0 = data cycle.
- bus_in  in  8  CPU bus value.
- bus_out  out  8  value driven onto CPU bus.
- bus_out_en  out  1  bus drive enable.
- dev_rx_data  out  8  head of the CPU-to-device FIFO.
- dev_rx_valid  out  1  CPU-to-device FIFO not empty.
- dev_rx_ready  in  1  device consumes the head when valid and ready.
- dev_tx_data  in  8  device byte for the CPU.
- dev_tx_valid  in  1  device offers a byte.
- dev_tx_ready  out  1  device-to-CPU FIFO not full.
- selected  out  1  device currently addressed.

Behaviour:
- Reset:
  - selected=0, both FIFOs empty, overrun=0, underrun=0, bus_out=0, bus_out_en=0, dev_rx_valid=0, dev_tx_ready=1.
  - The edge-detect history registers load the current io_clk_s and io_clk_e values. A strobe held high across reset release generates no event.
- Events: s_rise = io_clk_s & ~s_q and e_fall = ~io_clk_e & e_q, both registered on sys_clk. Exactly one action occurs per strobe pulse regardless of pulse length.
- OUT Addr (s_rise, io_input_or_output=1, io_data_or_address=1):
  - selected <= (bus_in == DEV_ADDR), visible the next cycle.
  - A mismatching address deselects the device.
- OUT Data (s_rise, io_input_or_output=1, io_data_or_address=0, selected):
  - Push bus_in into the rx FIFO.
  - If the FIFO is full: drop the byte, set sticky overrun, leave the FIFO unchanged.
- IN cycles (io_input_or_output=0, selected):
  - bus_out_en = io_clk_e & selected & ~io_input_or_output. This is combinational, with zero-cycle latency, so the bus is driven during the whole clk_e window.
  - bus_out = 0 whenever bus_out_en=0.
- IN Data (io_data_or_address=0):
  - bus_out = tx FIFO head, or 8'h00 if empty.
  - On e_fall: pop if non-empty; if empty, set sticky underrun.
- IN Addr (io_data_or_address=1):
  - bus_out = {4'b0, overrun, underrun, tx_not_empty, rx_not_full}.
  - On e_fall: clear overrun and underrun.
  - A flag set in the same cycle as the clear wins (it remains 1).
- Device side:
  - rx pop when dev_rx_valid & dev_rx_ready.
  - tx push when dev_tx_valid & dev_tx_ready.
  - dev_tx_ready derives from the registered count only. A full FIFO refuses a push even if a CPU pop occurs in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- Simultaneous pop and push on an empty FIFO: the push is accepted and the pop is ignored. For the tx side this also sets underrun.
- Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.
- io_clk_s and io_clk_e both rising in the same cycle is illegal; the bench asserts it never occurs.
- Unselected device: ignores OUT Data and IN cycles, holds bus_out_en=0, and still tracks OUT Addr.
- Reset mid-transfer clears the FIFOs and flags immediately and deselects the device. The CPU must re-address the device.

Decomposition:
- Shared package io_bus_pkg:
  - IO_DIR_IN=0, IO_DIR_OUT=1.
  - IO_CYC_DATA=0, IO_CYC_ADDR=1.
  - Status bit indices: ST_RX_NOT_FULL=0, ST_TX_NOT_EMPTY=1, ST_UNDERRUN=2, ST_OVERRUN=3.
  - DEV_ADDR defaults.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push, pop, data, full, empty, count). It is instantiated twice: rx and tx.

Test Plan:
- Address select: OUT Addr bus_in=8'h0F -> selected=1 next cycle. OUT Addr 8'h10 -> selected=0. OUT Data 8'hAA while deselected -> dev_rx_valid stays 0.
- OUT Data: after select, write 8'h11, 8'h22 with 3-cycle clk_s pulses -> dev_rx_data shows 8'h11 then 8'h22, one entry per pulse. With dev_rx_ready=1, dev_rx_valid drops after 2 pops.
- Overrun: DEPTH=4, dev_rx_ready=0, five OUT Data writes -> FIFO holds first 4 bytes. IN Addr reads 8'h08 (overrun=1, rx_not_full=0), then reads 8'h00 on the next IN Addr.
- IN Data: device pushes 8'h5A, 8'hC3 -> two IN Data cycles return 8'h5A then 8'hC3, with bus_out_en high only during io_clk_e. A third cycle returns 8'h00, and IN Addr then reads 8'h04 | rx_not_full = 8'h05.
- Full tx: device pushes until dev_tx_ready=0 after 4 bytes. A CPU IN Data pop in the same cycle as dev_tx_valid -> push refused that cycle, accepted the next.
- Reset mid-operation: reset asserted while io_clk_e is high, with 2 bytes in each FIFO -> next cycle bus_out_en=0, selected=0, dev_rx_valid=0, dev_tx_ready=1. Strobe still high after release -> no pop.
